// File: rtl/seq_mult_nibble_ctrl_pkg.sv
// Shared definitions for the nibble-serial multiplier controller.
//   NIB_W   : width of one operand slice fed to multiplier_4by4
//   state_t : controller state encoding (IDLE/CALC/DONE)
package seq_mult_nibble_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_nibble_ctrl_if.sv
// Request/result bundle for seq_mult_nibble_ctrl.
//   start   : request, accepted only in IDLE or DONE
//   dataa   : W-bit unsigned multiplicand
//   datab   : W-bit unsigned multiplier
//   busy    : high while the product is being accumulated
//   done    : one-cycle completion pulse
//   product : 2W-bit registered result
// master drives the request side; slave is the multiplier controller.
interface seq_mult_nibble_ctrl_if
  import seq_mult_nibble_ctrl_pkg::*;
#(
  parameter int N_NIB = 2
);

  localparam int W = NIB_W * N_NIB;

  logic           start;
  logic [W-1:0]   dataa;
  logic [W-1:0]   datab;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  modport master (
    output start, dataa, datab,
    input  busy, done, product
  );

  modport slave (
    input  start, dataa, datab,
    output busy, done, product
  );

endinterface

// File: rtl/multiplier_4by4.sv
// Combinational 4x4 unsigned multiplier (partial-product unit).
//   a, b : 4-bit unsigned operands
//   p    : 8-bit unsigned product a*b
module multiplier_4by4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  always_comb begin
    p = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (b[k]) p = p + ({4'b0000, a} << k);
    end
  end

endmodule

// File: rtl/seq_mult_nibble_ctrl.sv
// Nibble-serial multiplier: one 4x4 partial product per cycle, shifted and
// accumulated into a 2W-bit result over N_NIB*N_NIB cycles.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of seq_mult_nibble_ctrl_if (start/dataa/datab in,
//           busy/done/product out)
module seq_mult_nibble_ctrl
  import seq_mult_nibble_ctrl_pkg::*;
#(
  parameter int N_NIB = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  seq_mult_nibble_ctrl_if.slave bus
);

  localparam int W  = NIB_W * N_NIB;
  localparam int CW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_NIB - 1);

  state_t         state;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [CW-1:0]  i;
  logic [CW-1:0]  j;
  logic [2*W-1:0] acc;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [7:0]       pp;
  logic [2*W-1:0]   term;
  logic [2*W-1:0]   acc_next;
  int unsigned      shamt;

  // Nibble select as an explicit compare-mux so the index never exceeds
  // the operand width for non-power-of-two N_NIB.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned k = 0; k < N_NIB; k++) begin
      if (i == k[CW-1:0]) a_nib = a_reg[k*NIB_W +: NIB_W];
      if (j == k[CW-1:0]) b_nib = b_reg[k*NIB_W +: NIB_W];
    end
  end

  multiplier_4by4 u_mul (
    .a (a_nib),
    .b (b_nib),
    .p (pp)
  );

  always_comb begin
    shamt    = NIB_W * (32'(i) + 32'(j));
    term     = '0;
    term[7:0] = pp;
    term     = term << shamt;
    acc_next = acc + term;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      i           <= '0;
      j           <= '0;
      acc         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_reg    <= bus.dataa;
            b_reg    <= bus.datab;
            acc      <= '0;
            i        <= '0;
            j        <= '0;
            bus.busy <= 1'b1;
            state    <= CALC;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        CALC: begin
          acc <= acc_next;
          if (j == LAST) begin
            j <= '0;
            i <= i + CW'(1);
          end else begin
            j <= j + CW'(1);
          end
          if (i == LAST && j == LAST) begin
            bus.product <= acc_next;
            bus.done    <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= DONE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
